// File: rtl/sgd_x_updated_ctrl.sv
// Sequencer for the x_updated model BRAM: clears the rows, passes the SGD update
// pipeline through, waits for trailing writes, then streams the model out.
module sgd_x_updated_ctrl #(
    parameter int LANES         = 8,
    parameter int BANK_BITS     = 3,
    parameter int ADDR_W        = 10,
    parameter int RD_LATENCY    = 2,
    parameter int WR_PIPE_DEPTH = 4,
    parameter int SKID_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           dimension,
    input  logic                  epoch_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [ADDR_W-1:0]     upd_rd_addr,
    output logic [LANES*32-1:0]   upd_rd_data,
    input  logic                  upd_wr_en,
    input  logic [ADDR_W-1:0]     upd_wr_addr,
    input  logic [LANES*32-1:0]   upd_wr_data,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [LANES*32-1:0]   mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_W-1:0]     mem_wr_addr,
    output logic [LANES*32-1:0]   mem_wr_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [LANES*32-1:0]   dump_data,
    output logic                  dump_last
);

    localparam int DW    = LANES * 32;
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_UPDATE = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DUMP   = 3'd4;

    function automatic logic [31:0] count_ones(input logic [RD_LATENCY-1:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(SKID_DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [2:0]          state_r;
    logic [31:0]         rows_r;
    logic [31:0]         row_cnt_r;
    logic [31:0]         quiet_r;
    logic                armed_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                mem_wr_en_r;
    logic [ADDR_W-1:0]   mem_wr_addr_r;
    logic [DW-1:0]       mem_wr_data_r;
    logic [RD_LATENCY-1:0] rd_vld_r;
    logic [RD_LATENCY-1:0] rd_last_r;
    logic [PTR_W-1:0]    fifo_wr_ptr_r;
    logic [PTR_W-1:0]    fifo_rd_ptr_r;
    logic [CNT_W-1:0]    fifo_count_r;
    logic [DW-1:0]       fifo_data_r [SKID_DEPTH];
    logic                fifo_last_r [SKID_DEPTH];

    logic [31:0]         rows_s;
    logic [31:0]         in_flight_s;
    logic [31:0]         occupancy_s;
    logic                issue_s;
    logic                push_s;
    logic                pop_s;
    logic                last_pop_s;
    logic                wr_bad_s;
    logic                passthru_s;

    assign rows_s = {{BANK_BITS{1'b0}}, dimension[31:BANK_BITS]}
                  + {31'd0, (dimension[BANK_BITS-1:0] != {BANK_BITS{1'b0}})};

    // Read credits: a read may only be issued if its data is guaranteed a FIFO slot.
    assign in_flight_s = count_ones(rd_vld_r);
    assign occupancy_s = 32'(fifo_count_r) + in_flight_s;
    assign issue_s     = (state_r == ST_DUMP) && (row_cnt_r < rows_r)
                       && (occupancy_s < 32'(SKID_DEPTH));
    assign push_s      = rd_vld_r[RD_LATENCY-1];
    assign pop_s       = dump_valid && dump_ready;
    assign last_pop_s  = pop_s && fifo_last_r[fifo_rd_ptr_r];
    assign passthru_s  = (state_r == ST_UPDATE) || (state_r == ST_DRAIN);
    assign wr_bad_s    = upd_wr_en && !passthru_s;

    assign upd_rd_data = mem_rd_data;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign mem_wr_en   = mem_wr_en_r;
    assign mem_wr_addr = mem_wr_addr_r;
    assign mem_wr_data = mem_wr_data_r;
    assign dump_valid  = (fifo_count_r != {CNT_W{1'b0}});
    assign dump_data   = dump_valid ? fifo_data_r[fifo_rd_ptr_r] : {DW{1'b0}};
    assign dump_last   = dump_valid && fifo_last_r[fifo_rd_ptr_r];

    // BRAM read address owner per phase.
    always_comb begin
        mem_rd_addr = {ADDR_W{1'b0}};
        case (state_r)
            ST_UPDATE, ST_DRAIN: mem_rd_addr = upd_rd_addr;
            ST_DUMP:             mem_rd_addr = row_cnt_r[ADDR_W-1:0];
            default:             mem_rd_addr = {ADDR_W{1'b0}};
        endcase
    end

    // Phase sequencing, clear/update write port and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            rows_r        <= 32'd0;
            row_cnt_r     <= 32'd0;
            quiet_r       <= 32'd0;
            armed_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            mem_wr_addr_r <= {ADDR_W{1'b0}};
            mem_wr_data_r <= {DW{1'b0}};
        end else begin
            armed_r       <= 1'b1;
            done_r        <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            mem_wr_addr_r <= {ADDR_W{1'b0}};
            mem_wr_data_r <= {DW{1'b0}};
            if (wr_bad_s) begin
                err_r <= 1'b1;
            end
            if (passthru_s) begin
                mem_wr_en_r   <= upd_wr_en;
                mem_wr_addr_r <= upd_wr_en ? upd_wr_addr : {ADDR_W{1'b0}};
                mem_wr_data_r <= upd_wr_en ? upd_wr_data : {DW{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    // armed_r blocks a start that coincides with reset release
                    if (start && armed_r) begin
                        rows_r    <= rows_s;
                        row_cnt_r <= 32'd0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_CLEAR;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (row_cnt_r < rows_r) begin
                        mem_wr_en_r   <= 1'b1;
                        mem_wr_addr_r <= row_cnt_r[ADDR_W-1:0];
                        row_cnt_r     <= row_cnt_r + 32'd1;
                        if (row_cnt_r == rows_r - 32'd1) begin
                            state_r <= ST_UPDATE;
                        end
                    end else begin
                        state_r <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (epoch_done) begin
                        quiet_r <= 32'd0;
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (upd_wr_en) begin
                        quiet_r <= 32'd0;
                    end else if (quiet_r == 32'(WR_PIPE_DEPTH + 1)) begin
                        row_cnt_r <= 32'd0;
                        state_r   <= ST_DUMP;
                    end else begin
                        quiet_r <= quiet_r + 32'd1;
                    end
                end
                ST_DUMP: begin
                    if ((rows_r == 32'd0) || last_pop_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (issue_s) begin
                        row_cnt_r <= row_cnt_r + 32'd1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Dump read-return tracking and skid FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_r      <= {RD_LATENCY{1'b0}};
            rd_last_r     <= {RD_LATENCY{1'b0}};
            fifo_wr_ptr_r <= {PTR_W{1'b0}};
            fifo_rd_ptr_r <= {PTR_W{1'b0}};
            fifo_count_r  <= {CNT_W{1'b0}};
        end else begin
            rd_vld_r[0]  <= issue_s;
            rd_last_r[0] <= issue_s && (row_cnt_r == rows_r - 32'd1);
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_r[i]  <= rd_vld_r[i-1];
                rd_last_r[i] <= rd_last_r[i-1];
            end
            if (push_s) begin
                fifo_wr_ptr_r <= ptr_next(fifo_wr_ptr_r);
            end
            if (pop_s) begin
                fifo_rd_ptr_r <= ptr_next(fifo_rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Skid FIFO storage; contents are only observed while the entry is valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[fifo_wr_ptr_r] <= mem_rd_data;
            fifo_last_r[fifo_wr_ptr_r] <= rd_last_r[RD_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_sgd_x_updated_ctrl.sv
// Self-checking bench for sgd_x_updated_ctrl: BRAM model plus a row-level model of
// the expected final contents, with randomized updates and ready patterns.
module tb_sgd_x_updated_ctrl;

    localparam int LANES = 8;
    localparam int ADDR_W = 10;
    localparam int DW = LANES * 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       dimension = 32'd0;
    logic              epoch_done = 1'b0;
    logic              busy, done, err;
    logic [ADDR_W-1:0] upd_rd_addr = '0;
    logic [DW-1:0]     upd_rd_data;
    logic              upd_wr_en = 1'b0;
    logic [ADDR_W-1:0] upd_wr_addr = '0;
    logic [DW-1:0]     upd_wr_data = '0;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DW-1:0]     mem_rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DW-1:0]     mem_wr_data;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [DW-1:0]     dump_data;
    logic              dump_last;

    sgd_x_updated_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dimension(dimension),
        .epoch_done(epoch_done), .busy(busy), .done(done), .err(err),
        .upd_rd_addr(upd_rd_addr), .upd_rd_data(upd_rd_data),
        .upd_wr_en(upd_wr_en), .upd_wr_addr(upd_wr_addr), .upd_wr_data(upd_wr_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_last(dump_last)
    );

    always #5 clk = ~clk;

    // BRAM model with a two-cycle read
    logic [DW-1:0] bram [1024];
    logic [DW-1:0] rd_q1, rd_q2;
    int            wr_total = 0;
    bit            bad_addr_seen = 1'b0;
    assign mem_rd_data = rd_q2;

    always @(posedge clk) begin
        if (mem_wr_en) begin
            bram[mem_wr_addr] <= mem_wr_data;
            wr_total <= wr_total + 1;
            if (mem_wr_addr == 10'd700) bad_addr_seen <= 1'b1;
        end
        rd_q1 <= bram[mem_rd_addr];
        rd_q2 <= rd_q1;
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_mem [1024];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] d;
        for (int j = 0; j < LANES; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic start_run(input logic [31:0] dim, output int rows);
        rows = int'(dim / 32'd8) + ((dim % 32'd8) != 32'd0 ? 1 : 0);
        dimension = dim;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {255'd0, busy}, 256'd1);
    endtask

    task automatic clear_phase(input int rows, input bit misuse);
        int n = 0;
        for (int k = 0; k < rows + 3; k++) begin
            upd_wr_en   = misuse && (k == 0);
            upd_wr_addr = 10'd700;
            upd_wr_data = rand_row();
            tick();
            if (mem_wr_en) begin
                chk("clear_addr", DW'(mem_wr_addr), DW'(n));
                chk("clear_data", mem_wr_data, '0);
                n++;
            end
        end
        upd_wr_en = 1'b0;
        chk("clear_count", DW'(n), DW'(rows));
        for (int r = 0; r < rows; r++) exp_mem[r] = '0;
    endtask

    task automatic update_phase(input int rows, input int nwr);
        logic [ADDR_W-1:0] a;
        logic [DW-1:0]     d;
        for (int i = 0; i < nwr; i++) begin
            a = ADDR_W'($urandom_range(rows - 1, 0));
            d = rand_row();
            upd_wr_en = 1'b1; upd_wr_addr = a; upd_wr_data = d;
            upd_rd_addr = ADDR_W'($urandom_range(1023, 0));
            #1;
            chk("rd_addr_pass", DW'(mem_rd_addr), DW'(upd_rd_addr));
            tick();
            upd_wr_en = 1'b0;
            chk("upd_wr_en", {255'd0, mem_wr_en}, 256'd1);
            chk("upd_wr_addr", DW'(mem_wr_addr), DW'(a));
            chk("upd_wr_data", mem_wr_data, d);
            exp_mem[a] = d;
            tick();
            chk("upd_wr_one_cycle", {255'd0, mem_wr_en}, 256'd0);
            upd_rd_addr = a;
            tick();
            tick();
            chk("upd_rd_data", upd_rd_data, exp_mem[a]);
        end
    endtask

    task automatic drain_phase(input int rows, input int late_gap);
        logic [ADDR_W-1:0] a;
        logic [DW-1:0]     d;
        epoch_done = 1'b1;
        tick();
        epoch_done = 1'b0;
        if (late_gap > 0) begin
            repeat (late_gap - 1) tick();
            a = ADDR_W'($urandom_range(rows - 1, 0));
            d = rand_row();
            upd_wr_en = 1'b1; upd_wr_addr = a; upd_wr_data = d;
            tick();
            upd_wr_en = 1'b0;
            chk("late_wr_en", {255'd0, mem_wr_en}, 256'd1);
            chk("late_wr_data", mem_wr_data, d);
            exp_mem[a] = d;
        end
    endtask

    task automatic dump_phase(input int rows, input int mode);
        int            beats = 0;
        bit            stalled = 1'b0;
        bit            fin = 1'b0;
        bit            r, accepted;
        logic [DW-1:0] held_d;
        logic          held_l;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (stalled) begin
                chk("stall_valid", {255'd0, dump_valid}, 256'd1);
                chk("stall_data", dump_data, held_d);
                chk("stall_last", {255'd0, dump_last}, {255'd0, held_l});
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = ((c % 4) == 0) || ((c % 4) == 3);
                default: r = 1'($urandom_range(1, 0));
            endcase
            dump_ready = r;
            accepted = dump_valid && r;
            if (dump_valid) begin
                if (beats < rows) begin
                    chk("beat_data", dump_data, exp_mem[beats]);
                    chk("beat_last", {255'd0, dump_last}, {255'd0, (beats == rows - 1)});
                end else begin
                    chk("extra_beat", DW'(beats), DW'(rows - 1));
                end
            end
            stalled = dump_valid && !r;
            held_d = dump_data;
            held_l = dump_last;
            tick();
            if (accepted) beats++;
            fin = accepted && (beats == rows);
            chk("done_pulse", {255'd0, done}, {255'd0, fin});
            if (fin) chk("busy_fall", {255'd0, busy}, 256'd0);
        end
        dump_ready = 1'b0;
        chk("beat_count", DW'(beats), DW'(rows));
        tick();
        chk("done_single", {255'd0, done}, 256'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, {255'd0, busy}, 256'd0);
        chk({tag, "_done"}, {255'd0, done}, 256'd0);
        chk({tag, "_err"}, {255'd0, err}, 256'd0);
        chk({tag, "_mem_wr_en"}, {255'd0, mem_wr_en}, 256'd0);
        chk({tag, "_mem_rd_addr"}, DW'(mem_rd_addr), '0);
        chk({tag, "_mem_wr_addr"}, DW'(mem_wr_addr), '0);
        chk({tag, "_mem_wr_data"}, mem_wr_data, '0);
        chk({tag, "_dump_valid"}, {255'd0, dump_valid}, 256'd0);
        chk({tag, "_dump_last"}, {255'd0, dump_last}, 256'd0);
    endtask

    initial begin
        int rows;
        int wr_before;
        bit saw_valid, saw_done;

        // reset state, then a start coinciding with reset release
        start = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        chk("start_at_release_ignored", {255'd0, busy}, 256'd0);
        tick();

        // run A: dimension 20 -> 3 rows, late write during drain
        start_run(32'd20, rows);
        clear_phase(rows, 1'b0);
        update_phase(rows, 3);
        drain_phase(rows, 3);
        dump_phase(rows, 0);
        chk("err_clean", {255'd0, err}, 256'd0);

        // run B: 9 rows, stall pattern 1,0,0,1
        start_run(32'($urandom_range(72, 65)), rows);
        clear_phase(rows, 1'b0);
        update_phase(rows, 6);
        drain_phase(rows, 0);
        dump_phase(rows, 1);

        // run C: write during CLEAR is dropped and flagged
        start_run(32'd40, rows);
        clear_phase(rows, 1'b1);
        chk("err_set", {255'd0, err}, 256'd1);
        update_phase(rows, 2);
        drain_phase(rows, 2);
        dump_phase(rows, 2);
        chk("misuse_dropped", {255'd0, bad_addr_seen}, 256'd0);
        chk("err_sticky", {255'd0, err}, 256'd1);

        // run D: reset in the middle of DUMP
        start_run(32'd32, rows);
        clear_phase(rows, 1'b0);
        update_phase(rows, 1);
        drain_phase(rows, 0);
        dump_ready = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 50 && !saw_valid; c++) begin
            tick();
            saw_valid = dump_valid;
        end
        chk("dump_reached", {255'd0, saw_valid}, 256'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        dump_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wr_before = wr_total;
        repeat (10) tick();
        chk("no_write_after_reset", DW'(wr_total), DW'(wr_before));
        chk("idle_after_reset", {255'd0, busy}, 256'd0);

        // run E: dimension 0 -> no writes, no beats, still a done pulse
        wr_before = wr_total;
        start_run(32'd0, rows);
        clear_phase(rows, 1'b0);
        drain_phase(rows, 0);
        dump_ready = 1'b1;
        saw_valid = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 40 && !saw_done; c++) begin
            tick();
            saw_valid = saw_valid | dump_valid;
            saw_done = done;
        end
        dump_ready = 1'b0;
        chk("zero_done", {255'd0, saw_done}, 256'd1);
        chk("zero_no_beats", {255'd0, saw_valid}, 256'd0);
        chk("zero_no_writes", DW'(wr_total), DW'(wr_before));
        tick();
        chk("zero_idle", {255'd0, busy}, 256'd0);

        // run F: random size, random ready
        start_run(32'($urandom_range(60, 1)), rows);
        clear_phase(rows, 1'b0);
        update_phase(rows, 4);
        drain_phase(rows, 1);
        dump_phase(rows, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sgd_x_updated_ctrl.md
Name: sgd_x_updated_ctrl

Overview:
- Owns the x_updated model BRAM (one row = LANES x 32-bit weights) and sequences it through a training run: CLEAR, UPDATE, DRAIN, DUMP.
- CLEAR zeroes the rows. UPDATE passes the SGD update pipeline's read/write ports through to the BRAM. DRAIN waits for in-flight writes to land. DUMP streams the final model out through a valid/ready interface towards the host writer.
- Sits between the x_updated update pipeline and the BRAM primitive.

Parameters:
LANES, 8, 32-bit weights per BRAM row
BANK_BITS, 3, log2(LANES)
ADDR_W, 10, BRAM address width
RD_LATENCY, 2, BRAM read latency in cycles
WR_PIPE_DEPTH, 4, update pipeline read-to-write latency
SKID_DEPTH, 4, dump output FIFO depth; must be >= RD_LATENCY+1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin run (ignored unless IDLE)
dimension  in  32  number of features
epoch_done  in  1  pulse; update engine finished all epochs
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the last dump beat is accepted
err  out  1  sticky; an update write arrived outside UPDATE/DRAIN
upd_rd_addr  in  ADDR_W  update pipeline read address
upd_rd_data  out  LANES*32  BRAM read data returned to the pipeline
upd_wr_en  in  1  update pipeline write enable
upd_wr_addr  in  ADDR_W  update pipeline write address
upd_wr_data  in  LANES*32  update pipeline write data
mem_rd_addr  out  ADDR_W  BRAM read address
mem_rd_data  in  LANES*32  BRAM read data
mem_wr_en  out  1  BRAM write enable
mem_wr_addr  out  ADDR_W  BRAM write address
mem_wr_data  out  LANES*32  BRAM write data
dump_valid  out  1  dump beat valid
dump_ready  in  1  downstream accepts
dump_data  out  LANES*32  one BRAM row
dump_last  out  1  marks the final row

Behaviour:
- Reset (async assert, sync release): state=IDLE. The following outputs reset to 0: busy, done, err, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data, dump_valid, dump_last. Skid FIFO is emptied. All counters are 0.
- Reset mid-run aborts immediately. No BRAM write follows reset deassertion until the next start.
- rows = dimension[31:BANK_BITS] + (dimension[BANK_BITS-1:0]!=0). It is latched one cycle after start. dimension==0 gives rows=0.
- upd_rd_data = mem_rd_data at all times (combinational passthrough).
- IDLE: on start, latch rows and go to CLEAR.
- CLEAR:
  - mem_wr_en=1, mem_wr_data=0, mem_wr_addr counts 0..rows-1, one row per cycle.
  - After row rows-1 is written, go to UPDATE.
  - rows=0: go straight to UPDATE with no write.
- UPDATE:
  - mem_rd_addr=upd_rd_addr.
  - mem_wr_en/addr/data = upd_wr_* registered once, i.e. 1 cycle latency.
  - On epoch_done, go to DRAIN.
- DRAIN:
  - Write passthrough continues.
  - A quiet counter clears on every upd_wr_en and otherwise increments.
  - When quiet == WR_PIPE_DEPTH+1, go to DUMP.
- DUMP:
  - Read pointer issues mem_rd_addr 0..rows-1.
  - A read is issued only when fifo_count + in_flight < SKID_DEPTH. in_flight counts reads issued less than RD_LATENCY cycles ago.
  - Returned data is pushed into the skid FIFO after RD_LATENCY cycles. dump_valid = FIFO not empty.
  - dump_last=1 on the beat carrying row rows-1.
  - When that beat is accepted (dump_valid & dump_ready & dump_last): done pulses 1 cycle and state goes to IDLE.
  - rows=0: done pulses on DUMP entry with no beats.
- dump_data/dump_valid/dump_last are held stable while dump_ready=0. There is no loss or duplication of rows under any ready pattern.
- upd_wr_en in IDLE, CLEAR or DUMP: the write is dropped (never reaches the BRAM) and err is set. err clears only on reset.
- epoch_done outside UPDATE is ignored. start while busy is ignored.
- start coincident with reset deassertion is ignored.

Test Plan:
- dimension=20, LANES=8, start -> rows=3; mem_wr_en high exactly 3 cycles, addr 0,1,2, data 0; then state UPDATE.
- UPDATE: upd_wr_en=1, addr=1, data=0x…05 -> mem_wr_* shows addr 1, same data, exactly 1 cycle later. upd_rd_addr=2 -> mem_rd_addr=2 in the same cycle.
- epoch_done followed by a late upd_wr_en 3 cycles later -> that write still lands. DUMP starts WR_PIPE_DEPTH+1 cycles after the last write.
- DUMP, rows=3, dump_ready=1 -> 3 beats with rows 0,1,2 in order, dump_last on the 3rd beat, done pulse, busy falls next cycle.
- DUMP, rows=9, dump_ready toggling 1,0,0,1 repeatedly -> 9 beats in order, no duplicates, outputs stable while stalled, FIFO never exceeds SKID_DEPTH.
- Misuse: upd_wr_en during CLEAR -> err=1 and no BRAM write with that address. rst_n low mid-DUMP -> all outputs 0, state IDLE. dimension=0 -> no writes, done pulse, no dump beats.
